// File: rtl/serial_add_sub_pkg.sv
// serial_add_sub_pkg: shared FSM state type and operation constants
// for the bit-serial adder/subtractor.
package serial_add_sub_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam logic ADD = 1'b1;
    localparam logic SUB = 1'b0;

endpackage

// File: rtl/serial_add_sub_if.sv
// serial_add_sub_if: start/done bundle; master drives start, add_sub, A, B, Cin;
// slave returns busy, done, Result, Cout (+ ovf with SERIAL_ADD_SUB_OVF_EN).
interface serial_add_sub_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             add_sub;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Result;
    logic             Cout;
`ifdef SERIAL_ADD_SUB_OVF_EN
    logic             ovf;
`endif

    modport master (
        output start, add_sub, A, B, Cin,
        input  busy, done, Result, Cout
`ifdef SERIAL_ADD_SUB_OVF_EN
        , input ovf
`endif
    );

    modport slave (
        input  start, add_sub, A, B, Cin,
        output busy, done, Result, Cout
`ifdef SERIAL_ADD_SUB_OVF_EN
        , output ovf
`endif
    );

endinterface

// File: rtl/serial_add_sub_full_add_sub_bit.sv
// full_add_sub_bit: combinational 1-bit add/subtract cell.
// Ports: a, b, c (carry/borrow in), add_sub (1=add); s, c_out.
module full_add_sub_bit
    import serial_add_sub_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic add_sub,
    output logic s,
    output logic c_out
);

    assign s = a ^ b ^ c;

    // Add: majority carry. Subtract: borrow out of a - b - c.
    assign c_out = (add_sub == ADD)
                 ? ((a & b) | (a & c) | (b & c))
                 : ((~a & b) | (~a & c) | (b & c));

endmodule

// File: rtl/serial_add_sub.sv
// serial_add_sub: LSB-first serial A+B+Cin / A-B-Cin over WIDTH cycles.
// Ports: clk, rst_n (sync, active-low), bus (slave); ovf via SERIAL_ADD_SUB_OVF_EN.
module serial_add_sub
    import serial_add_sub_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    serial_add_sub_if.slave bus
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state_q;
    state_t           state_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic             op_q;
    logic             c_q;
    logic             cout_q;
    logic             s_bit;
    logic             c_next;
    logic             accept;
    logic             step;
    logic             last;
`ifdef SERIAL_ADD_SUB_OVF_EN
    logic             ovf_q;
`endif

    assign last = (cnt_q == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        step    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                step = 1'b1;
                if (last) state_d = DONE;
            end
            DONE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    full_add_sub_bit u_cell (
        .a       (a_q[0]),
        .b       (b_q[0]),
        .c       (c_q),
        .add_sub (op_q),
        .s       (s_bit),
        .c_out   (c_next)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            res_q  <= '0;
            op_q   <= 1'b0;
            c_q    <= 1'b0;
            cout_q <= 1'b0;
`ifdef SERIAL_ADD_SUB_OVF_EN
            ovf_q  <= 1'b0;
`endif
        end else if (accept) begin
            a_q   <= bus.A;
            b_q   <= bus.B;
            op_q  <= bus.add_sub;
            c_q   <= bus.Cin;
            cnt_q <= '0;
        end else if (step) begin
            a_q   <= a_q >> 1;
            b_q   <= b_q >> 1;
            c_q   <= c_next;
            // Entering at the MSB end lands bit 0 at Result[0] after WIDTH steps.
            res_q <= {s_bit, res_q[WIDTH-1:1]};
            cnt_q <= cnt_q + CW'(1);
            if (last) begin
                cout_q <= c_next;
`ifdef SERIAL_ADD_SUB_OVF_EN
                // Carry (or borrow) into MSB differs from out of MSB.
                ovf_q  <= c_q ^ c_next;
`endif
            end
        end
    end

    assign bus.busy   = (state_q == SHIFT);
    assign bus.done   = (state_q == DONE);
    assign bus.Result = res_q;
    assign bus.Cout   = cout_q;
`ifdef SERIAL_ADD_SUB_OVF_EN
    assign bus.ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_sub.sv
// tb_serial_add_sub: scoreboard bench for serial_add_sub (WIDTH=4).
// Define SERIAL_ADD_SUB_OVF_EN to also check ovf.
module tb_serial_add_sub;

    localparam int W   = 4;
    localparam int MAX = 20;

    typedef struct {
        logic [W-1:0] res;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic clk;
    logic rst_n;
    int   compared;
    int   mismatched;
    exp_t sb[$];
    exp_t e;

    serial_add_sub_if #(.WIDTH(W)) bus ();

    serial_add_sub #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(bit op, logic [W-1:0] a,
                                   logic [W-1:0] b, bit cin);
        exp_t   r;
        int     ua;
        int     ub;
        int     sa;
        int     sb_v;
        int     u;
        int     v;
        ua   = int'(a);
        ub   = int'(b);
        sa   = a[W-1] ? ua - (1 << W) : ua;
        sb_v = b[W-1] ? ub - (1 << W) : ub;
        if (op) begin
            u = ua + ub + int'(cin);
            v = sa + sb_v + int'(cin);
        end else begin
            u = ua - ub - int'(cin);
            v = sa - sb_v - int'(cin);
        end
        u      = u & ((1 << (W + 1)) - 1);
        r.res  = W'(u);
        r.cout = u[W];
        r.ovf  = (v > (1 << (W - 1)) - 1) || (v < -(1 << (W - 1)));
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst_n && bus.done === 1'b1) begin
            compared++;
            if (sb.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_done: done=1 required no done");
            end else begin
                e = sb.pop_front();
                compared++;
                if (bus.Result !== e.res) begin
                    mismatched++;
                    $display("FAIL result: got %h want %h",
                             bus.Result, e.res);
                end
                compared++;
                if (bus.Cout !== e.cout) begin
                    mismatched++;
                    $display("FAIL cout: got %b want %b", bus.Cout, e.cout);
                end
`ifdef SERIAL_ADD_SUB_OVF_EN
                compared++;
                if (bus.ovf !== e.ovf) begin
                    mismatched++;
                    $display("FAIL ovf: got %b want %b", bus.ovf, e.ovf);
                end
`endif
            end
        end
    end

    task automatic start_op(bit op, logic [W-1:0] a, logic [W-1:0] b,
                            bit cin, bit push);
        bus.add_sub = op;
        bus.A       = a;
        bus.B       = b;
        bus.Cin     = cin;
        bus.start   = 1'b1;
        if (push) sb.push_back(model(op, a, b, cin));
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (bus.done !== 1'b1 && n < MAX) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset;
        bus.start = 1'b1;
        repeat (2) @(negedge clk);
        compared++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_ctl: busy=%b done=%b want 0 0",
                     bus.busy, bus.done);
        end
        compared++;
        if (bus.Result !== '0 || bus.Cout !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_data: Result=%h Cout=%b want 0 0",
                     bus.Result, bus.Cout);
        end
`ifdef SERIAL_ADD_SUB_OVF_EN
        compared++;
        if (bus.ovf !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_ovf: got %b want 0", bus.ovf);
        end
`endif
        bus.start = 1'b0;
        rst_n     = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_vec(bit op, logic [W-1:0] a, logic [W-1:0] b,
                            bit cin, logic [W-1:0] xr, bit xc, string nm);
        int n;
        start_op(op, a, b, cin, 1'b1);
        compared++;
        if (bus.busy !== 1'b1) begin
            mismatched++;
            $display("FAIL %s_busy: got %b want 1", nm, bus.busy);
        end
        wait_done(n);
        compared++;
        if (n !== W) begin
            mismatched++;
            $display("FAIL %s_latency: got %0d want %0d", nm, n, W);
        end
        compared++;
        if (bus.Result !== xr || bus.Cout !== xc) begin
            mismatched++;
            $display("FAIL %s_value: got %h/%b want %h/%b",
                     nm, bus.Result, bus.Cout, xr, xc);
        end
        @(negedge clk);
    endtask

    task automatic test_ignore_start;
        int n;
        start_op(1'b1, 4'd9, 4'd5, 1'b1, 1'b1);
        @(negedge clk);
        bus.A       = 4'd3;
        bus.B       = 4'd7;
        bus.add_sub = 1'b0;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(n);
        compared++;
        if (n !== W - 2) begin
            mismatched++;
            $display("FAIL ignore_latency: got %0d want %0d", n, W - 2);
        end
        @(negedge clk);
        compared++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            mismatched++;
            $display("FAIL ignore_queued: busy=%b done=%b want 0 0",
                     bus.busy, bus.done);
        end
    endtask

    task automatic test_back_to_back;
        int n;
        bus.add_sub = 1'b0;
        bus.A       = 4'd3;
        bus.B       = 4'd5;
        bus.Cin     = 1'b0;
        bus.start   = 1'b1;
        sb.push_back(model(1'b0, 4'd3, 4'd5, 1'b0));
        @(negedge clk);
        bus.add_sub = 1'b1;
        bus.A       = 4'd12;
        bus.B       = 4'd6;
        bus.Cin     = 1'b1;
        sb.push_back(model(1'b1, 4'd12, 4'd6, 1'b1));
        wait_done(n);
        compared++;
        if (n !== W) begin
            mismatched++;
            $display("FAIL b2b_first: got %0d want %0d", n, W);
        end
        @(negedge clk);
        bus.start = 1'b0;
        compared++;
        if (bus.busy !== 1'b1) begin
            mismatched++;
            $display("FAIL b2b_accept: busy=%b want 1", bus.busy);
        end
        wait_done(n);
        compared++;
        if (n !== W) begin
            mismatched++;
            $display("FAIL b2b_second: got %0d want %0d", n, W);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_abort;
        int pulses;
        start_op(1'b1, 4'd9, 4'd5, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        compared++;
        if (bus.busy !== 1'b0 || bus.Result !== '0 || bus.Cout !== 1'b0) begin
            mismatched++;
            $display("FAIL abort_state: busy=%b Result=%h Cout=%b want 0 0 0",
                     bus.busy, bus.Result, bus.Cout);
        end
        rst_n  = 1'b1;
        pulses = 0;
        repeat (2 * W) begin
            @(negedge clk);
            if (bus.done === 1'b1) pulses++;
        end
        compared++;
        if (pulses !== 0) begin
            mismatched++;
            $display("FAIL abort_done: got %0d pulses want 0", pulses);
        end
    endtask

    task automatic test_exhaustive;
        int n;
        int bad;
        bad = 0;
        for (int op = 0; op < 2; op++)
            for (int a = 0; a < 16; a++)
                for (int b = 0; b < 16; b++)
                    for (int c = 0; c < 2; c++) begin
                        start_op(op[0], W'(a), W'(b), c[0], 1'b1);
                        wait_done(n);
                        if (n !== W) bad++;
                    end
        @(negedge clk);
        compared++;
        if (bad !== 0) begin
            mismatched++;
            $display("FAIL exh_latency: got %0d late ops want 0", bad);
        end
    endtask

    initial begin
        compared    = 0;
        mismatched  = 0;
        rst_n       = 1'b0;
        bus.start   = 1'b0;
        bus.add_sub = 1'b0;
        bus.A       = '0;
        bus.B       = '0;
        bus.Cin     = 1'b0;
        test_reset();
        test_vec(1'b1, 4'd9, 4'd5, 1'b1, 4'hF, 1'b0, "add_9_5");
        test_vec(1'b1, 4'hF, 4'd1, 1'b0, 4'h0, 1'b1, "add_f_1");
        test_vec(1'b0, 4'd3, 4'd5, 1'b0, 4'hE, 1'b1, "sub_3_5");
        test_vec(1'b0, 4'd7, 4'd2, 1'b1, 4'h4, 1'b0, "sub_7_2");
        test_vec(1'b1, 4'd7, 4'd1, 1'b0, 4'h8, 1'b0, "add_7_1");
        test_vec(1'b0, 4'd8, 4'd1, 1'b0, 4'h7, 1'b0, "sub_8_1");
        test_ignore_start();
        test_back_to_back();
        test_reset_abort();
        test_exhaustive();
        compared++;
        if (sb.size() !== 0) begin
            mismatched++;
            $display("FAIL scoreboard_drain: %0d left want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule

// File: doc/serial_add_sub.md
# serial_add_sub

Bit-serial counterpart of the team's 4-bit parallel adder/subtractor. It accepts the same operand set (A, B, Cin, add_sub) through a start/done handshake and computes the identical Result/Cout pair LSB-first over WIDTH clock cycles using a single one-bit adder/subtractor cell. It is used where area matters more than latency and as a cross-check engine against the parallel unit: both must produce bit-identical outputs for every operand set.

## Interface
- WIDTH, 4: operand and result width in bits; must be at least 2.
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  reset, synchronous and active-low; sampled on the rising edge of clk.
- start  input  1  request; sampled only in IDLE or DONE.
- add_sub  input  1  operation select: 1 = A+B+Cin, 0 = A−B−Cin.
- A  input  WIDTH  first operand (unsigned).
- B  input  WIDTH  second operand (unsigned).
- Cin  input  1  carry-in for add; borrow-in for subtract.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle pulse; Result and Cout are valid from this cycle onward.
- Result  output  WIDTH  low WIDTH bits of the result.
- Cout  output  1  carry-out for add; borrow for subtract (bit WIDTH of A−B−Cin in WIDTH+1-bit two's complement).
- ovf  output  1  signed overflow; present only when SERIAL_ADD_SUB_OVF_EN is defined.

## Operation
- FSM states: IDLE, SHIFT, DONE.
  - IDLE → SHIFT when start = 1.
  - SHIFT → DONE after WIDTH bit steps.
  - DONE → SHIFT when start = 1; otherwise DONE → IDLE.
- On accept: latch A, B, and add_sub into shift registers; load the carry/borrow flop with Cin; clear the bit counter.
- Each SHIFT cycle:
  - Process bit i = counter.
  - Add: sum = a^b^c; c' = majority(a, b, c).
  - Subtract: diff = a^b^c; c' = (~a&b) | (~a&c) | (b&c).
  - Shift diff/sum into Result from the MSB end, so Result ends correctly aligned.
  - Update the carry flop with c'; increment the counter.
- Cout = final carry flop value. This matches {1'b0,A} ± {1'b0,B} ± Cin, truncated to WIDTH+1 bits, bit WIDTH.
- Counter width is $clog2(WIDTH+1); the counter never wraps within an operation.
- start while busy is ignored, with no queuing. A and B may change freely after the accept edge.
- Result and Cout hold their last values until the next accept. They are not cleared when returning to IDLE.
- Reset values: state = IDLE; busy = 0; done = 0; Result = 0; Cout = 0; ovf = 0; counter = 0.
- Reset asserted during SHIFT aborts the operation: outputs return to reset values and done is never issued.

## Timing
- Edge 0 samples start = 1.
- Edges 1..WIDTH each process one bit; busy = 1 after edge 0 through edge WIDTH.
- After edge WIDTH: state = DONE, busy = 0, done = 1, Result and Cout final.
- Latency: WIDTH+1 edges from accept to done visible, i.e. done appears WIDTH cycles after busy rises.
- Back-to-back operation: start high during the DONE cycle is accepted at that edge, giving a throughput of one operation per WIDTH+1 cycles.
- Simultaneous rst_n = 0 and start = 1: reset wins.
- During SHIFT, Result holds partial, shifted contents; consumers must use done only.

## Configuration
- SERIAL_ADD_SUB_OVF_EN defined:
  - ovf port exists.
  - At the MSB step, ovf is set to carry_in_to_MSB ^ carry_out_of_MSB. For subtract, use the borrow chain equivalently: overflow occurs when operand signs differ and the result sign differs from A.
  - ovf is valid with done and held with Result.
- Macro not defined: port and logic are absent; all other behaviour is identical.

## Structure
- Package serial_add_sub_pkg:
  - state_t enum {IDLE, SHIFT, DONE}.
  - ADD = 1'b1 and SUB = 1'b0 constants for add_sub.
- Sub-module full_add_sub_bit: combinational 1-bit cell with inputs a, b, c, add_sub and outputs s, c_out. It is instantiated once.

## Test plan
- add, A=9, B=5, Cin=1 → after WIDTH+1 edges: done = 1, Result = 4'hF, Cout = 0.
- add, A=4'hF, B=1, Cin=0 → Result = 0, Cout = 1. With OVF_EN: ovf = 0.
- sub, A=3, B=5, Cin=0 → Result = 4'hE, Cout = 1. Then sub, A=7, B=2, Cin=1 → Result = 4, Cout = 0.
- OVF_EN, add, A=7, B=1, Cin=0 → Result = 8, ovf = 1. Then sub, A=8, B=1, Cin=0 → Result = 7, ovf = 1.
- start pulsed again two cycles after accept with different operands → ignored; first result delivered unchanged. Start held high through DONE → second operation accepted, done again WIDTH+1 edges later.
- rst_n low for one cycle at bit 2 of an operation → busy = 0, Result = 0, and no done pulse. Then exhaustively compare all 2×16×16×2 operand sets against the parallel A±B±Cin model.
